// File: rtl/local_flit_injector.sv
// Local-port transmit side: packet request plus byte stream in, head/body/tail flits out.
// Flow control uses credits against the router's local input buffer.
module local_flit_injector #(
   parameter int CREDITS = 4,
   parameter int CW      = 3,
   parameter int LEN_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pkt_req_valid,
   output logic             pkt_req_ready,
   input  logic [2:0]       pkt_dest_x,
   input  logic [2:0]       pkt_dest_y,
   input  logic [LEN_W-1:0] pkt_len,
   input  logic             data_valid,
   input  logic [7:0]       data,
   output logic             data_ready,
   output logic [9:0]       flit_out,
   output logic             flit_valid,
   input  logic             credit_in,
   output logic [CW-1:0]    credit_count,
   output logic             busy,
   output logic             len_err
);

   typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD} state_t;

   state_t           state_q, state_d;
   logic [2:0]       dest_x_q, dest_x_d;
   logic [2:0]       dest_y_q, dest_y_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic [9:0]       flit_q, flit_d;
   logic             flit_valid_q, flit_valid_d;
   logic [CW-1:0]    credit_q, credit_d;
   logic             len_err_q, len_err_d;
   logic             have_credit;

   assign have_credit   = (credit_q != '0);
   assign pkt_req_ready = (state_q == IDLE);
   assign data_ready    = (state_q == PAYLOAD) && have_credit;
   assign busy          = (state_q != IDLE);
   assign flit_out      = flit_q;
   assign flit_valid    = flit_valid_q;
   assign credit_count  = credit_q;
   assign len_err       = len_err_q;

   always_comb begin
      state_d      = state_q;
      dest_x_d     = dest_x_q;
      dest_y_d     = dest_y_q;
      remaining_d  = remaining_q;
      flit_d       = '0;
      flit_valid_d = 1'b0;
      len_err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (pkt_req_valid) begin
               if (pkt_len != '0) begin
                  dest_x_d    = pkt_dest_x;
                  dest_y_d    = pkt_dest_y;
                  remaining_d = pkt_len;
                  state_d     = HEAD;
               end else begin
                  len_err_d = 1'b1;
               end
            end
         end
         HEAD: begin
            if (have_credit) begin
               flit_d       = {2'b00, dest_x_q, dest_y_q, 2'b11};
               flit_valid_d = 1'b1;
               state_d      = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (data_valid && have_credit) begin
               flit_valid_d = 1'b1;
               remaining_d  = remaining_q - 1'b1;
               if (remaining_q == LEN_W'(1)) begin
                  flit_d  = {data, 2'b10};
                  state_d = IDLE;
               end else begin
                  flit_d = {data, 2'b01};
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A returned credit and an issued flit on the same edge cancel; surplus credits are dropped.
   always_comb begin
      credit_d = credit_q;
      if (flit_valid_d && !credit_in)
         credit_d = credit_q - 1'b1;
      else if (!flit_valid_d && credit_in && (credit_q != CW'(CREDITS)))
         credit_d = credit_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         dest_x_q     <= '0;
         dest_y_q     <= '0;
         remaining_q  <= '0;
         flit_q       <= '0;
         flit_valid_q <= 1'b0;
         credit_q     <= CW'(CREDITS);
         len_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         dest_x_q     <= dest_x_d;
         dest_y_q     <= dest_y_d;
         remaining_q  <= remaining_d;
         flit_q       <= flit_d;
         flit_valid_q <= flit_valid_d;
         credit_q     <= credit_d;
         len_err_q    <= len_err_d;
      end
   end

endmodule

// File: tb/tb_local_flit_injector.sv
// Bench for local_flit_injector: vector table, hand-written corner sequences,
// then random traffic against a queue-based flit/credit model.
module tb_local_flit_injector;

   localparam int CREDITS = 4;
   localparam int CW      = 3;
   localparam int LEN_W   = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             pkt_req_valid, pkt_req_ready;
   logic [2:0]       pkt_dest_x, pkt_dest_y;
   logic [LEN_W-1:0] pkt_len;
   logic             data_valid, data_ready;
   logic [7:0]       data;
   logic [9:0]       flit_out;
   logic             flit_valid, credit_in, busy, len_err;
   logic [CW-1:0]    credit_count;

   local_flit_injector #(.CREDITS(CREDITS), .CW(CW), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset),
      .pkt_req_valid(pkt_req_valid), .pkt_req_ready(pkt_req_ready),
      .pkt_dest_x(pkt_dest_x), .pkt_dest_y(pkt_dest_y), .pkt_len(pkt_len),
      .data_valid(data_valid), .data(data), .data_ready(data_ready),
      .flit_out(flit_out), .flit_valid(flit_valid),
      .credit_in(credit_in), .credit_count(credit_count),
      .busy(busy), .len_err(len_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [9:0] hf(input logic [2:0] x, input logic [2:0] y);
      return {2'b00, x, y, 2'b11};
   endfunction
   function automatic logic [9:0] bf(input logic [7:0] b);
      return {b, 2'b01};
   endfunction
   function automatic logic [9:0] tf(input logic [7:0] b);
      return {b, 2'b10};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       rst, rv;
      logic [2:0] dx, dy;
      logic [3:0] len;
      logic       dv;
      logic [7:0] d;
      logic       cr;
      logic [9:0] e_flit;
      logic       e_fv;
      logic [2:0] e_cnt;
      logic       e_busy, e_lerr, e_rrdy, e_drdy;
   } vec_t;

   vec_t tbl[20];

   // random-phase model state
   logic [9:0] exp_q[$];
   logic [7:0] byte_q[$];
   int         outstanding;
   logic       exp_lerr;

   task automatic rnd_cycle(input bit drain);
      logic       req_acc, byte_acc, cr;
      logic [3:0] len;
      logic [7:0] b;
      pkt_req_valid = !drain && ($urandom_range(0, 3) == 0);
      pkt_dest_x    = 3'($urandom);
      pkt_dest_y    = 3'($urandom);
      pkt_len       = 4'($urandom_range(0, 8));
      data_valid    = drain || ($urandom_range(0, 3) != 0);
      data          = (byte_q.size() != 0) ? byte_q[0] : 8'($urandom);
      cr            = (outstanding > 0) && (drain || $urandom_range(0, 2) == 0);
      credit_in     = cr;
      len           = pkt_len;
      @(negedge clk);
      req_acc  = pkt_req_valid && pkt_req_ready;
      byte_acc = data_valid && data_ready;
      cyc();
      exp_lerr = req_acc && (len == 0);
      if (req_acc && len != 0) begin
         exp_q.push_back(hf(pkt_dest_x, pkt_dest_y));
         for (int k = 0; k < int'(len); k++) begin
            b = 8'($urandom);
            byte_q.push_back(b);
            exp_q.push_back((k == int'(len) - 1) ? tf(b) : bf(b));
         end
      end
      if (byte_acc) begin
         if (byte_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rnd byte consumed with no packet open got=1 want=0");
         end else void'(byte_q.pop_front());
      end
      if (flit_valid) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rnd unexpected flit got=%0h want=none", flit_out);
         end else chk("rnd flit", flit_out, exp_q.pop_front());
         outstanding++;
      end else begin
         chk("rnd idle flit_out", flit_out, 0);
      end
      if (cr) outstanding--;
      chk("rnd credit_count", credit_count, CREDITS - outstanding);
      chk("rnd len_err", len_err, exp_lerr);
   endtask

   initial begin
      int nflits;
      reset = 1'b0; pkt_req_valid = 0; pkt_dest_x = 0; pkt_dest_y = 0; pkt_len = 0;
      data_valid = 0; data = 0; credit_in = 0;

      //        rst rv dx dy len dv d     cr | flit        fv cnt busy lerr rrdy drdy
      tbl[0]  = '{0, 0, 0, 0, 0, 0, 8'h00, 0, 10'h0,       0, 4, 0, 0, 1, 0};
      tbl[1]  = '{1, 1, 2, 5, 3, 0, 8'h00, 0, 10'h0,       0, 4, 1, 0, 0, 0};
      tbl[2]  = '{1, 0, 0, 0, 0, 0, 8'h00, 0, hf(2, 5),    1, 3, 1, 0, 0, 1};
      tbl[3]  = '{1, 0, 0, 0, 0, 1, 8'hA1, 1, bf(8'hA1),   1, 3, 1, 0, 0, 1};
      tbl[4]  = '{1, 0, 0, 0, 0, 1, 8'hB2, 1, bf(8'hB2),   1, 3, 1, 0, 0, 1};
      tbl[5]  = '{1, 0, 0, 0, 0, 1, 8'hC3, 1, tf(8'hC3),   1, 3, 0, 0, 1, 0};
      tbl[6]  = '{1, 0, 0, 0, 0, 0, 8'h00, 1, 10'h0,       0, 4, 0, 0, 1, 0};
      tbl[7]  = '{1, 1, 7, 7, 0, 0, 8'h00, 0, 10'h0,       0, 4, 0, 1, 1, 0};
      tbl[8]  = '{1, 0, 0, 0, 0, 0, 8'h00, 1, 10'h0,       0, 4, 0, 0, 1, 0};
      tbl[9]  = '{1, 1, 0, 0, 1, 0, 8'h00, 0, 10'h0,       0, 4, 1, 0, 0, 0};
      tbl[10] = '{1, 0, 0, 0, 0, 0, 8'h00, 0, hf(0, 0),    1, 3, 1, 0, 0, 1};
      tbl[11] = '{1, 0, 0, 0, 0, 1, 8'hFF, 0, tf(8'hFF),   1, 2, 0, 0, 1, 0};
      tbl[12] = '{1, 1, 1, 2, 2, 0, 8'h00, 1, 10'h0,       0, 3, 1, 0, 0, 0};
      tbl[13] = '{1, 0, 0, 0, 0, 0, 8'h00, 0, hf(1, 2),    1, 2, 1, 0, 0, 1};
      tbl[14] = '{1, 0, 0, 0, 0, 0, 8'h00, 1, 10'h0,       0, 3, 1, 0, 0, 1};
      tbl[15] = '{1, 0, 0, 0, 0, 1, 8'h5A, 0, bf(8'h5A),   1, 2, 1, 0, 0, 1};
      tbl[16] = '{1, 0, 0, 0, 0, 1, 8'h3C, 1, tf(8'h3C),   1, 2, 0, 0, 1, 0};
      tbl[17] = '{1, 0, 0, 0, 0, 0, 8'h00, 1, 10'h0,       0, 3, 0, 0, 1, 0};
      tbl[18] = '{1, 0, 0, 0, 0, 0, 8'h00, 1, 10'h0,       0, 4, 0, 0, 1, 0};
      tbl[19] = '{1, 0, 0, 0, 0, 0, 8'h00, 1, 10'h0,       0, 4, 0, 0, 1, 0};

      for (int i = 0; i < 20; i++) begin
         reset = tbl[i].rst; pkt_req_valid = tbl[i].rv; pkt_dest_x = tbl[i].dx;
         pkt_dest_y = tbl[i].dy; pkt_len = tbl[i].len; data_valid = tbl[i].dv;
         data = tbl[i].d; credit_in = tbl[i].cr;
         cyc();
         chk($sformatf("row%0d flit_out", i), flit_out, tbl[i].e_flit);
         chk($sformatf("row%0d flit_valid", i), flit_valid, tbl[i].e_fv);
         chk($sformatf("row%0d credit_count", i), credit_count, tbl[i].e_cnt);
         chk($sformatf("row%0d busy", i), busy, tbl[i].e_busy);
         chk($sformatf("row%0d len_err", i), len_err, tbl[i].e_lerr);
         chk($sformatf("row%0d pkt_req_ready", i), pkt_req_ready, tbl[i].e_rrdy);
         chk($sformatf("row%0d data_ready", i), data_ready, tbl[i].e_drdy);
      end
      credit_in = 0; data_valid = 0; pkt_req_valid = 0;

      // credit exhaustion: len=6 with no credits returned
      pkt_req_valid = 1; pkt_dest_x = 3; pkt_dest_y = 1; pkt_len = 6;
      cyc();
      pkt_req_valid = 0; pkt_len = 0; data_valid = 1;
      nflits = 0;
      for (int i = 0; i < 8; i++) begin
         data = 8'h10 + 8'(i);
         cyc();
         nflits += int'(flit_valid);
      end
      chk("exhaust flit count", nflits, 4);
      chk("exhaust data_ready", data_ready, 0);
      chk("exhaust busy", busy, 1);
      chk("exhaust credit_count", credit_count, 0);
      credit_in = 1;
      cyc();
      credit_in = 0;
      chk("exhaust credit edge flit_valid", flit_valid, 0);
      chk("exhaust credit edge count", credit_count, 1);
      nflits = 0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         nflits += int'(flit_valid);
      end
      chk("exhaust released flits", nflits, 1);
      chk("exhaust count after release", credit_count, 0);

      // mid-packet reset after head and one body flit
      reset = 0; data_valid = 0;
      cyc();
      reset = 1;
      pkt_req_valid = 1; pkt_dest_x = 3; pkt_dest_y = 4; pkt_len = 3;
      cyc();
      pkt_req_valid = 0;
      cyc();
      chk("midrst head", flit_out, hf(3, 4));
      data_valid = 1; data = 8'h77;
      cyc();
      chk("midrst body", flit_out, bf(8'h77));
      reset = 0;
      cyc();
      reset = 1;
      chk("midrst flit_valid", flit_valid, 0);
      chk("midrst flit_out", flit_out, 0);
      chk("midrst busy", busy, 0);
      chk("midrst credit_count", credit_count, CREDITS);
      nflits = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         nflits += int'(flit_valid);
      end
      chk("midrst no tail", nflits, 0);
      data_valid = 0;
      pkt_req_valid = 1; pkt_dest_x = 5; pkt_dest_y = 6; pkt_len = 1;
      cyc();
      pkt_req_valid = 0;
      cyc();
      chk("midrst next head", flit_out, hf(5, 6));
      chk("midrst next head valid", flit_valid, 1);
      data_valid = 1; data = 8'h42;
      cyc();
      chk("midrst next tail", flit_out, tf(8'h42));
      data_valid = 0;
      reset = 0;
      cyc();
      reset = 1;

      // random traffic against the queue model
      outstanding = 0;
      for (int i = 0; i < 2000; i++) rnd_cycle(1'b0);
      for (int i = 0; i < 400 && (exp_q.size() != 0 || byte_q.size() != 0); i++) rnd_cycle(1'b1);
      chk("rnd drained flits", exp_q.size(), 0);
      chk("rnd drained bytes", byte_q.size(), 0);
      pkt_req_valid = 0; data_valid = 0; credit_in = 0;
      cyc();
      chk("rnd final busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
